// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame bit counts and the
// baud divisor helper. Used by the stimulus transmitter and the byte decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CNT_W  = $clog2(DATA_BITS);

  // Clocks per bit; fractional part is simply dropped.
  function automatic int baud_div(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_stim_tx_if.sv
// Byte push handshake between a writer (host/bench) and the UART stimulus
// transmitter. The writer offers a byte with in_valid; the transmitter
// accepts it in any cycle where in_ready is high.
interface uart_stim_tx_if;

  logic                           in_valid;
  logic [uart_pkg::DATA_BITS-1:0] in_byte;
  logic                           in_ready;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready
  );

endinterface

// File: rtl/uart_stim_tx_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy counter.
// Read data is the head entry (fall-through), valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// Buffered 8N1/8N2 UART serializer driving the SoC UART_RX line.
// Bytes pushed through the handshake interface are queued in a FIFO and
// sent LSB first; queued bytes follow each other with no idle gap.
// Optional even parity bit after the data bits: define UART_STIM_PARITY_EN.
module uart_stim_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_stim_tx_if.slave               bus,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int DIV       = baud_div(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int STOP_CLKS = DIV * STOP_BITS;
  localparam int CNT_W     = $clog2(STOP_CLKS + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_CLKS - 1);

  uart_state_t            state, state_next;
  logic [CNT_W-1:0]       baud_cnt, baud_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   tx_reg, tx_next;

  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   rdata;
  logic                   full;
  logic                   empty;

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign uart_tx      = tx_reg;
  assign busy         = (state != IDLE) || !empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_byte),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Registered frame state; reset drives the line high and abandons any frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_reg <= '0;
      tx_reg   <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      data_reg <= data_next;
      tx_reg   <= tx_next;
    end
  end

  // Frame sequencing: each phase holds the line for a full baud count, and
  // the last stop clock pops the next byte so frames run back to back.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    data_next  = data_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          data_next  = rdata;
          tx_next    = 1'b0;
          baud_next  = DIV_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_next  = DIV_LOAD;
          bit_next   = '0;
          tx_next    = data_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_STIM_PARITY_EN
            baud_next  = DIV_LOAD;
            tx_next    = ^data_reg;
            state_next = PARITY;
`else
            baud_next  = STOP_LOAD;
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            baud_next = DIV_LOAD;
            bit_next  = bit_cnt + 1'b1;
            tx_next   = data_reg[bit_cnt + 1'b1];
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
`ifdef UART_STIM_PARITY_EN
      PARITY: begin
        if (baud_cnt == '0) begin
          baud_next  = STOP_LOAD;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            data_next  = rdata;
            tx_next    = 1'b0;
            baud_next  = DIV_LOAD;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Sticky flag for bytes offered while the FIFO was full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (bus.in_valid && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: a scoreboard queue of expected bytes filled by the
// stimulus, and a line monitor that decodes uart_tx and checks each frame.
// A second instance with two stop bits covers the longer frame.
// Parity checks are compiled in when UART_STIM_PARITY_EN is defined.
module tb_uart_stim_tx;

  localparam int DIV  = 234;
  localparam int HALF = DIV / 2;
`ifdef UART_STIM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME    = DIV * (10 + PAR);
  localparam int FRAME2   = DIV * (11 + PAR);
  localparam int STOP_IDX = 9 + PAR;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_tx, busy, overflow;
  logic [4:0] fifo_count;
  logic       uart_tx2, busy2, overflow2;
  logic [4:0] fifo_count2;

  uart_stim_tx_if bus ();
  uart_stim_tx_if bus2 ();

  uart_stim_tx #(
    .CLK_FREQ_MHZ (27),
    .BAUD_RATE    (115200),
    .FIFO_DEPTH   (16),
    .STOP_BITS    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  uart_stim_tx #(
    .CLK_FREQ_MHZ (27),
    .BAUD_RATE    (115200),
    .FIFO_DEPTH   (16),
    .STOP_BITS    (2)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus2),
    .uart_tx    (uart_tx2),
    .busy       (busy2),
    .fifo_count (fifo_count2),
    .overflow   (overflow2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic idleBus();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain_timeout"}, 32'(n >= limit), 0);
  endtask

  // Line monitor: find start edges, sample mid-bit, compare against the queue.
  logic       prev_tx = 1'b1;
  bit         mon_active = 1'b0;
  int         mon_t = 0;
  int         mon_idx = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] exp_byte;
`ifdef UART_STIM_PARITY_EN
  logic       mon_par = 1'b0;
`endif

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      prev_tx    = 1'b1;
    end else begin
      if (mon_active) begin
        mon_t++;
        if (mon_t == HALF + mon_idx * DIV) begin
          if (mon_idx == 0) begin
            checkOutput("start_bit", 32'(uart_tx), 0);
          end else if (mon_idx <= 8) begin
            mon_byte = {uart_tx, mon_byte[7:1]};
`ifdef UART_STIM_PARITY_EN
          end else if (mon_idx < STOP_IDX) begin
            mon_par = uart_tx;
`endif
          end else begin
            checkOutput("stop_bit", 32'(uart_tx), 1);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL rx_unexpected: got=0x%0h want=none", mon_byte);
            end else begin
              exp_byte = exp_q.pop_front();
              checkOutput("rx_byte", 32'(mon_byte), 32'(exp_byte));
`ifdef UART_STIM_PARITY_EN
              checkOutput("rx_parity", 32'(mon_par), 32'(^exp_byte));
`endif
            end
            mon_active = 1'b0;
          end
          mon_idx++;
        end
      end else if (prev_tx && !uart_tx) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_idx    = 0;
        start_q.push_back(cyc);
      end
      prev_tx = uart_tx;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int   lows;
  logic exp_lvl;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus2.in_valid = 1'b0;
    bus2.in_byte  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(uart_tx), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_ready", 32'(bus.in_ready), 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: single 0x55 frame, edge timing and busy fall
    $display("[TB] test 1: single byte 0x55");
    applyStimulus(8'h55, 1'b1);
    idleBus();
    checkOutput("t1_tx_before_pop", 32'(uart_tx), 1);
    checkOutput("t1_count_after_push", 32'(fifo_count), 1);
    @(negedge clk);
    checkOutput("t1_start_first", 32'(uart_tx), 0);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_count_after_pop", 32'(fifo_count), 0);
    repeat (DIV - 1) @(negedge clk);
    checkOutput("t1_start_last", 32'(uart_tx), 0);
    @(negedge clk);
    checkOutput("t1_bit0", 32'(uart_tx), 1);
    repeat (DIV) @(negedge clk);
    checkOutput("t1_bit1", 32'(uart_tx), 0);
    repeat (FRAME - 2 * DIV - 1) @(negedge clk);
    checkOutput("t1_busy_last", 32'(busy), 1);
    checkOutput("t1_stop_level", 32'(uart_tx), 1);
    @(negedge clk);
    checkOutput("t1_busy_fall", 32'(busy), 0);
    waitDrain("t1", 3 * FRAME);

    // Test 2: "Hi\n" back to back, frames must abut exactly
    $display("[TB] test 2: back-to-back Hi newline");
    start_q.delete();
    applyStimulus(8'h48, 1'b1);
    applyStimulus(8'h69, 1'b1);
    applyStimulus(8'h0A, 1'b1);
    idleBus();
    waitDrain("t2", 5 * FRAME);
    checkOutput("t2_frames", 32'(start_q.size()), 3);
    if (start_q.size() == 3) begin
      checkOutput("t2_gap01", 32'(start_q[1] - start_q[0]), FRAME);
      checkOutput("t2_gap12", 32'(start_q[2] - start_q[1]), FRAME);
    end

    // Test 3: 18 consecutive pushes, 17 fit, last one overflows
    $display("[TB] test 3: overflow");
    for (int k = 0; k < 18; k++) begin
      applyStimulus(8'(8'h10 + k), k < 17);
      checkOutput("t3_ready", 32'(bus.in_ready), 32'(k < 17));
    end
    idleBus();
    checkOutput("t3_overflow", 32'(overflow), 1);
    checkOutput("t3_count_full", 32'(fifo_count), 16);
    waitDrain("t3", 20 * FRAME);
    checkOutput("t3_overflow_sticky", 32'(overflow), 1);

    // Test 4: reset in the middle of a frame
    $display("[TB] test 4: reset mid-frame");
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    idleBus();
    repeat (998) @(negedge clk);
    checkOutput("t4_count_pre", 32'(fifo_count), 1);
    checkOutput("t4_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("t4_tx", 32'(uart_tx), 1);
    checkOutput("t4_count", 32'(fifo_count), 0);
    checkOutput("t4_overflow", 32'(overflow), 0);
    checkOutput("t4_busy", 32'(busy), 0);
    reset = 1'b1;
    applyStimulus(8'hC3, 1'b1);
    idleBus();
    waitDrain("t4", 3 * FRAME);

    // Test 5: two stop bits, 0xFF keeps the line high after start
    $display("[TB] test 5: two stop bits");
    @(negedge clk);
    checkOutput("t5_ready", 32'(bus2.in_ready), 1);
    bus2.in_valid = 1'b1;
    bus2.in_byte  = 8'hFF;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    checkOutput("t5_idle", 32'(uart_tx2), 1);
    @(negedge clk);
    checkOutput("t5_start_first", 32'(uart_tx2), 0);
    repeat (DIV - 1) @(negedge clk);
    checkOutput("t5_start_last", 32'(uart_tx2), 0);
    lows = 0;
    for (int i = 0; i < FRAME2 - DIV; i++) begin
      @(negedge clk);
      exp_lvl = (i / DIV == 8) ? (PAR == 0) : 1'b1;
      if (uart_tx2 !== exp_lvl) lows++;
    end
    checkOutput("t5_level_errors", 32'(lows), 0);
    checkOutput("t5_busy_last", 32'(busy2), 1);
    @(negedge clk);
    checkOutput("t5_busy_fall", 32'(busy2), 0);
    checkOutput("t5_count", 32'(fifo_count2), 0);
    checkOutput("t5_overflow", 32'(overflow2), 0);

`ifdef UART_STIM_PARITY_EN
    // Test 6: parity bit values
    $display("[TB] test 6: parity");
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'h03, 1'b1);
    idleBus();
    waitDrain("t6", 4 * FRAME);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
